// File: rtl/coord_add_arbiter.sv
// coord_add_arbiter
//   Two-requester round-robin front end for a shared external dual-lane
//   10-bit adder. A request carries a packed position {Y,X} and a packed
//   signed delta {dY,dX}. The winner's operands are added in one pass. If
//   either lane of that sum falls outside its range, a second pass adds a
//   per-lane correction, so the result wraps into 0..LIM-1.
//
// Ports
//   clk, rst_n        : clock and asynchronous active-low reset
//   req0 / req1       : requests, held by the requester until its grant
//   a0 / a1           : packed positions {Y[19:10], X[9:0]}
//   b0 / b1           : packed deltas, each lane 10-bit two's complement
//   gnt0 / gnt1       : one-cycle grant pulse (the ADD cycle)
//   valid0 / valid1   : one-cycle result pulse; sum carries the result
//   sum               : registered wrapped result, held until the next result
//   busy              : high whenever the FSM is not IDLE
//   add_a / add_b     : operands to the shared adder (0 when not in use)
//   add_s             : adder result, per-lane sum modulo 1024
module coord_add_arbiter #(
    parameter int X_LIM = 640,
    parameter int Y_LIM = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [19:0] a0,
    input  logic [19:0] a1,
    input  logic [19:0] b0,
    input  logic [19:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        valid0,
    output logic        valid1,
    output logic [19:0] sum,
    output logic        busy,
    output logic [19:0] add_a,
    output logic [19:0] add_b,
    input  logic [19:0] add_s
);

    // A positive delta can only overshoot the top of the range, so the fix
    // subtracts LIM. A negative delta can only wrap below zero, which lands
    // the lane in LIM..1023, so the fix subtracts (1024-LIM). Adding LIM
    // modulo 1024 does the same.
    localparam logic [9:0] X_LIM_L    = 10'(X_LIM);
    localparam logic [9:0] Y_LIM_L    = 10'(Y_LIM);
    localparam logic [9:0] X_CORR_POS = 10'(1024 - X_LIM);
    localparam logic [9:0] X_CORR_NEG = 10'(X_LIM);
    localparam logic [9:0] Y_CORR_POS = 10'(1024 - Y_LIM);
    localparam logic [9:0] Y_CORR_NEG = 10'(Y_LIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_owner;      // 1 when requester 1 owns the current operation
    logic        r_last1;      // 1 when requester 1 received the last grant
    logic [19:0] r_add_a;      // holds the latched a in ADD and res in FIX
    logic [19:0] r_add_b;      // holds the latched b in ADD and the corrections in FIX

    logic        w_win1;
    logic        w_fix_x;
    logic        w_fix_y;
    logic [19:0] w_corr;

    // Under contention the requester that did not get the last grant wins.
    // A lone requester always wins.
    assign w_win1 = req1 && (!req0 || !r_last1);

    // NOTE: every output of this block is assigned a default first. Without
    // the defaults, a lane that needs no fix would leave w_corr unassigned on
    // some paths, and synthesis would infer a latch.
    always_comb begin
        w_fix_x = (add_s[9:0]   >= X_LIM_L);
        w_fix_y = (add_s[19:10] >= Y_LIM_L);
        w_corr  = '0;
        if (w_fix_x) begin
            w_corr[9:0]   = r_add_b[9]  ? X_CORR_NEG : X_CORR_POS;
        end
        if (w_fix_y) begin
            w_corr[19:10] = r_add_b[19] ? Y_CORR_NEG : Y_CORR_POS;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments. Every
    // register then sees values from before the edge, no matter how the
    // statements are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= 1'b0;
            r_last1 <= 1'b1;   // so requester 0 wins the first contention
            r_add_a <= '0;
            r_add_b <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            valid0  <= 1'b0;
            valid1  <= 1'b0;
            busy    <= 1'b0;
            sum     <= '0;
        end else begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ADD;
                        busy    <= 1'b1;
                        r_owner <= w_win1;
                        r_last1 <= w_win1;
                        gnt0    <= !w_win1;
                        gnt1    <= w_win1;
                        r_add_a <= w_win1 ? a1 : a0;
                        r_add_b <= w_win1 ? b1 : b0;
                    end
                end
                ADD: begin
                    if (w_fix_x || w_fix_y) begin
                        // Both lanes are corrected in one pass. A lane that
                        // needs no fix gets a correction of 0.
                        r_state <= FIX;
                        r_add_a <= add_s;
                        r_add_b <= w_corr;
                    end else begin
                        r_state <= RESP;
                        r_add_a <= '0;
                        r_add_b <= '0;
                        sum     <= add_s;
                        valid0  <= !r_owner;
                        valid1  <= r_owner;
                    end
                end
                FIX: begin
                    r_state <= RESP;
                    r_add_a <= '0;
                    r_add_b <= '0;
                    sum     <= add_s;
                    valid0  <= !r_owner;
                    valid1  <= r_owner;
                end
                RESP: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign add_a = r_add_a;
    assign add_b = r_add_b;

endmodule

// File: doc/coord_add_arbiter.md
COORD_ADD_ARBITER -- requirements
Module: coord_add_arbiter

Interface
REQ-001 SHALL have parameter X_LIM, default 640: column count; low lane (bits 9:0) wraps in range 0..X_LIM-1.
REQ-002 SHALL have parameter Y_LIM, default 480: row count; high lane (bits 19:10) wraps in range 0..Y_LIM-1.
REQ-003 SHALL have port clk  input  1  single clock, all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0/req1  input  1 each  requester 0/1 request, held until its gnt.
REQ-006 SHALL have ports a0/a1  input  20 each  packed position {Y,X}, each lane below its LIM.
REQ-007 SHALL have ports b0/b1  input  20 each  packed delta {dY,dX}, each lane 10-bit two's complement.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each  one-cycle grant pulse, operands captured.
REQ-009 SHALL have ports valid0/valid1  output  1 each  one-cycle pulse, sum holds the result for that requester.
REQ-010 SHALL have port sum  output  20  registered packed wrapped result {Y,X}.
REQ-011 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-012 SHALL have ports add_a/add_b  output  20 each  operands to the shared external dual-lane 10-bit adder.
REQ-013 SHALL have port add_s  input  20  adder result; each lane is the sum modulo 1024 with no carry between lanes.

Function
REQ-014 SHALL implement FSM states IDLE, ADD, FIX, RESP.
REQ-015 IDLE with any req SHALL at the clock edge: latch winner's a/b, record owner, go to ADD.
REQ-016 Arbitration SHALL be round-robin: when both requesters request, the one not granted last wins; a lone requester always wins.
REQ-017 gnt of owner SHALL be high for exactly the ADD cycle.
REQ-018 req inputs SHALL be ignored outside IDLE.
REQ-019 ADD SHALL drive add_a=latched a and add_b=latched b, and at the edge load res with add_s.
REQ-020 For each lane, a fix SHALL be needed when add_s lane >= LIM.
REQ-021 Positive delta (sign bit 0) correction SHALL be -LIM mod 1024.
REQ-022 Negative delta correction SHALL be -(1024-LIM) mod 1024.
REQ-023 A lane with no fix needed SHALL use correction 0.
REQ-024 Corrections SHALL be latched at the ADD edge.
REQ-025 ADD SHALL go to FIX if either lane needs a fix, else to RESP.
REQ-026 FIX SHALL drive add_a=res and add_b=latched corrections, load res with add_s, and go to RESP; both lanes are fixed in the same single pass.
REQ-027 RESP SHALL pulse valid of owner for one cycle with sum=res, then go to IDLE; sum SHALL hold its value until the next RESP.
REQ-028 Latency from the req-sampling edge to valid SHALL be 2 cycles without a fix and 3 cycles with a fix.
REQ-029 add_a and add_b SHALL be 0 in IDLE and RESP.
REQ-030 A new request SHALL be accepted in the IDLE cycle immediately after RESP.
REQ-031 A position lane >= LIM on input SHALL receive the single correction pass only, with no further guarantee.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, with gnt0, gnt1, valid0, valid1 and busy at 0, sum=0, and add_a, add_b at 0.
REQ-033 rst_n low SHALL set the round-robin pointer so req0 wins the first contention.
REQ-034 Reset asserted mid-operation SHALL abort it: no valid pulse follows, and the request must be reissued.

Verification
REQ-035 Plain step: req0, a0={Y=10,X=20}, b0={+1,+1} -> gnt0 in ADD, FIX skipped, valid0 two cycles later, sum={11,21}.
REQ-036 X wrap: req1, a1={5,639}, b1={0,+1} -> FIX visited, valid1 three cycles later, sum={5,0}.
REQ-037 Y underflow: a0={0,100}, b0={0x3FF,0} -> sum={479,100}.
REQ-038 Both lanes wrap: a0={479,0}, b0={+1,0x3FF} -> one FIX pass, sum={0,639}.
REQ-039 Contention: req0 and req1 held from reset -> grants in order gnt0, gnt1, gnt0, each with a matching valid and no overlap.
REQ-040 Reset during FIX -> all outputs 0 at once, no valid after release, and the next req0 is served normally.
